neosd_clk_gen: RTL and testbench
================================

Name: neosd_clk_gen

Overview:
Parametrised SD-card clock generator for the neosd host. It divides the system clock through a prescaler select and a fine divider, and gates SD CLK from N requesters and M stall sources. It adds glitch-free divider/prescaler reconfiguration, separate rise/fall strobes for CMD/DAT sampling and driving, and a post-request tail of TAIL_CYCLES clocks (SD spec: 8 clocks after command/response end).

Parameters:
NUM_REQ, 3, number of clock-request inputs (OR-combined)
NUM_STALL, 2, number of stall inputs (OR-combined)
DIV_W, 8, fine divider width; half-period = (div+1) prescaler enables
SEL_W, 3, prescaler select width; clkgen_i width = 2**SEL_W
TAIL_CYCLES, 8, SD clocks emitted after all requests drop; 0 disables the tail

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
clkgen_i  in  2**SEL_W  prescaler enable pulses from the SoC clock generator
clksel_i  in  SEL_W  prescaler select
clkdiv_i  in  DIV_W  fine divider value
clkhs_i  in  1  high-speed mode: bypass prescaler (enable every cycle)
req_i  in  NUM_REQ  clock requests
stall_i  in  NUM_STALL  stall requests (e.g. FIFO full/empty)
sd_clk_en_o  out  1  combinational: clock requested or in tail, and not stalled
rise_strb_o  out  1  1-cycle pulse in the cycle sd_clk_o goes 0->1
fall_strb_o  out  1  1-cycle pulse in the cycle sd_clk_o goes 1->0
tail_busy_o  out  1  tail counter non-zero
sd_clk_o  out  1  SD CLK pin, registered

Behaviour:
- Reset (async, immediate, including mid-operation): sd_clk_o=0, rise/fall strobes=0, tail_busy_o=0, divider count=0, phase=0, tail=0, shadow div_q='1, sel_q=0, hs_q=0.
- Shadow config: div_q/sel_q/hs_q load from clkdiv_i/clksel_i/clkhs_i when the clock is idle (sd_clk_o=0 and not en), or on the tick ending a high half (1->0 instant). A change during a high half therefore takes effect from the following low half; no half-period is ever shorter than min(old, new).
- Prescale enable pe = hs_q | clkgen_i[sel_q].
- Divider: on pe, if cnt==div_q then tick=1, cnt=0; else cnt+=1. cnt only resets on rst_i. div_q=0 with hs_q=1 -> tick every cycle -> SD CLK = clk_i/2.
- Phase ph toggles on every tick, free-running whether or not the clock is gated; phase 0 = low half, phase 1 = high half.
- en = (|req_i | tail!=0) & ~|stall_i; sd_clk_en_o = en (combinational).
- Tick with ph 0->1: if en, sd_clk_o<=1 and rise_strb_o<=1; otherwise sd_clk_o stays 0 and no strobe.
- Tick with ph 1->0: sd_clk_o<=0; fall_strb_o<=1 only if sd_clk_o was 1.
- Gating is evaluated only at rising instants, so a high pulse, once started, always completes full length (no runt pulses). Stall or request drop mid-high completes the current pulse and suppresses the next.
- Tail: a registered request-any flag is kept. On its 1->0 transition the tail loads TAIL_CYCLES. It decrements by 1 on each emitted rising edge while |req_i==0. A new request clears it to 0. Stalls do not decrement the tail, so stalled tails are extended. Tail width = $clog2(TAIL_CYCLES+1).
- Simultaneous request re-assert and tail expiry: the request wins and the clock continues without a gap.
- Strobes are single-cycle and mutually exclusive.

Test Plan:
- Reset then hs=1, div=0, req_i=3'b001 -> sd_clk_o toggles every clk_i cycle (period 2). Rise strobe is coincident with every 0->1 transition. Assert rst_i mid-high -> sd_clk_o=0 in the same cycle.
- hs=0, sel=2, clkgen_i[2] pulsing every 4 cycles, div=1 -> half-period 8 cycles, period 16. Change div to 3 mid-high -> current high stays 8 cycles, then 16-cycle halves.
- req asserted for 3 SD clocks then dropped, TAIL_CYCLES=8 -> exactly 11 rise strobes, tail_busy_o high through the 8th tail rise, then sd_clk_o stays 0.
- Assert stall_i[1] during a high half with div=2 -> high half lasts 3 cycles, no further rise while stalled. Release -> next rise lands on the next ph 0->1 tick.
- During tail, assert stall for 4 SD periods -> tail count is frozen and the total of 8 tail rises is preserved. Re-assert req_i[2] on the final tail rise -> no gap in sd_clk_o.
- TAIL_CYCLES=0 build: drop req -> no extra rise after the current pulse; tail_busy_o never asserts.

Source files
------------

// File: rtl/neosd_clk_gen.sv
// neosd SD CLK generator: prescaler + fine divider, request/stall gating,
// glitch-free reconfiguration and a post-request clock tail.
module neosd_clk_gen #(
  parameter int NUM_REQ     = 3,
  parameter int NUM_STALL   = 2,
  parameter int DIV_W       = 8,
  parameter int SEL_W       = 3,
  parameter int TAIL_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2**SEL_W-1:0]   clkgen_i,
  input  logic [SEL_W-1:0]      clksel_i,
  input  logic [DIV_W-1:0]      clkdiv_i,
  input  logic                  clkhs_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_STALL-1:0]  stall_i,
  output logic                  sd_clk_en_o,
  output logic                  rise_strb_o,
  output logic                  fall_strb_o,
  output logic                  tail_busy_o,
  output logic                  sd_clk_o
);

  localparam int TW =
    (TAIL_CYCLES > 0) ? $clog2(TAIL_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TAIL_INIT = TW'(TAIL_CYCLES);

  logic [DIV_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             hs_q, hs_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic             sd_clk_q, sd_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [TW-1:0]    tail_q, tail_d;
  logic             req_any_q, req_any_d;

  logic req_any;
  logic stall_any;
  logic tail_nz;
  logic en;
  logic pe;
  logic tick;
  logic rise_tick;
  logic fall_tick;
  logic cfg_ld;

  always_comb begin
    req_any   = |req_i;
    stall_any = |stall_i;
    tail_nz   = (tail_q != '0);
    en        = (req_any | tail_nz) & ~stall_any;
    pe        = hs_q | clkgen_i[sel_q];
    tick      = pe & (cnt_q == div_q);
    rise_tick = tick & ~ph_q;
    fall_tick = tick & ph_q;
    // Reconfigure only while idle-low or exactly at the end of a high half
    cfg_ld    = (~sd_clk_q & ~en) | fall_tick;
  end

  always_comb begin
    div_d = div_q;
    sel_d = sel_q;
    hs_d  = hs_q;
    if (cfg_ld) begin
      div_d = clkdiv_i;
      sel_d = clksel_i;
      hs_d  = clkhs_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (pe) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    if (tick) begin
      ph_d = ~ph_q;
    end
  end

  // Gating is sampled only at rising instants, so pulses never get cut short
  always_comb begin
    sd_clk_d = sd_clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (1'b1)
      rise_tick: begin
        sd_clk_d = en;
        rise_d   = en;
      end
      fall_tick: begin
        sd_clk_d = 1'b0;
        fall_d   = sd_clk_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_any_d = req_any;
    tail_d    = tail_q;
    if (req_any) begin
      tail_d = '0;
    end else if (req_any_q) begin
      tail_d = TAIL_INIT;
    end else if (rise_tick && en && tail_nz) begin
      tail_d = tail_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '1;
      sel_q     <= '0;
      hs_q      <= 1'b0;
      cnt_q     <= '0;
      ph_q      <= 1'b0;
      sd_clk_q  <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      tail_q    <= '0;
      req_any_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      sel_q     <= sel_d;
      hs_q      <= hs_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      sd_clk_q  <= sd_clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      tail_q    <= tail_d;
      req_any_q <= req_any_d;
    end
  end

  assign sd_clk_en_o = en;
  assign rise_strb_o = rise_q;
  assign fall_strb_o = fall_q;
  assign tail_busy_o = tail_nz;
  assign sd_clk_o    = sd_clk_q;

endmodule

// File: tb/tb_neosd_clk_gen.sv
// Directed testbench for neosd_clk_gen (TAIL_CYCLES=8 plus a TAIL_CYCLES=0
// instance sharing the same stimulus).
module tb_neosd_clk_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] clkgen_i;
  logic [2:0] clksel_i;
  logic [7:0] clkdiv_i;
  logic       clkhs_i;
  logic [2:0] req_i;
  logic [1:0] stall_i;

  logic sd_clk_en_o, rise_strb_o, fall_strb_o, tail_busy_o, sd_clk_o;
  logic en0, rise0, fall0, busy0, sd0;

  int n_chk  = 0;
  int n_fail = 0;
  int gcnt   = 0;
  bit gen_on = 0;
  bit busy0_seen = 0;

  always #5 clk_i = ~clk_i;

  neosd_clk_gen #(.TAIL_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clkgen_i(clkgen_i),
    .clksel_i(clksel_i), .clkdiv_i(clkdiv_i), .clkhs_i(clkhs_i),
    .req_i(req_i), .stall_i(stall_i), .sd_clk_en_o(sd_clk_en_o),
    .rise_strb_o(rise_strb_o), .fall_strb_o(fall_strb_o),
    .tail_busy_o(tail_busy_o), .sd_clk_o(sd_clk_o)
  );

  neosd_clk_gen #(.TAIL_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .clkgen_i(clkgen_i),
    .clksel_i(clksel_i), .clkdiv_i(clkdiv_i), .clkhs_i(clkhs_i),
    .req_i(req_i), .stall_i(stall_i), .sd_clk_en_o(en0),
    .rise_strb_o(rise0), .fall_strb_o(fall0),
    .tail_busy_o(busy0), .sd_clk_o(sd0)
  );

  task automatic step();
    @(negedge clk_i);
    gcnt++;
    clkgen_i = (gen_on && (gcnt % 4 == 0)) ? 8'h04 : 8'h00;
    if (busy0) busy0_seen = 1;
  endtask

  task automatic do_reset(input logic hs, input logic [2:0] sel,
                          input logic [7:0] dv);
    rst_i = 1; gen_on = 0; req_i = 0; stall_i = 0;
    clkhs_i = hs; clksel_i = sel; clkdiv_i = dv;
    step(); step();
    rst_i = 0;
    step();
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 1;
    step();
    while (sd_clk_o === lvl && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic wait_level(input logic lvl);
    int k = 0;
    while (sd_clk_o !== lvl && k < 200) begin
      step();
      k++;
    end
    n_chk++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL wait_level: sd_clk_o=%b never reached %b", sd_clk_o, lvl);
    end
  endtask

  task automatic test_reset();
    rst_i = 1; req_i = 0; stall_i = 0; clkgen_i = 0;
    clkhs_i = 0; clksel_i = 0; clkdiv_i = 0;
    #1;
    n_chk++;
    if ({sd_clk_o, rise_strb_o, fall_strb_o, tail_busy_o, sd_clk_en_o}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected 00000",
        {sd_clk_o, rise_strb_o, fall_strb_o, tail_busy_o, sd_clk_en_o});
    end
  endtask

  task automatic test_hs_div0();
    logic [2:0] exp;
    do_reset(1'b1, 3'd0, 8'd0);
    req_i = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k % 2 == 1) ? 3'b110 : 3'b001;
      n_chk++;
      if ({sd_clk_o, rise_strb_o, fall_strb_o} !== exp) begin
        n_fail++;
        $display("FAIL hs_toggle[%0d]: got %b expected %b", k,
          {sd_clk_o, rise_strb_o, fall_strb_o}, exp);
      end
    end
    step();
    n_chk++;
    if (sd_clk_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_pre_rst: sd_clk_o=%b expected 1", sd_clk_o);
    end
    rst_i = 1;
    #1;
    n_chk++;
    if ({sd_clk_o, rise_strb_o, fall_strb_o, tail_busy_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_high_rst: got %b expected 0000",
        {sd_clk_o, rise_strb_o, fall_strb_o, tail_busy_o});
    end
    step();
    rst_i = 0;
  endtask

  task automatic test_prescale_reconfig();
    int n;
    do_reset(1'b0, 3'd2, 8'd1);
    gen_on = 1;
    req_i  = 3'b001;
    wait_level(1'b1);
    run_len(1'b1, n);
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL ps_high: got %0d expected 8", n);
    end
    run_len(1'b0, n);
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL ps_low: got %0d expected 8", n);
    end
    clkdiv_i = 8'd3;
    run_len(1'b1, n);
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL reconf_cur_high: got %0d expected 8", n);
    end
    run_len(1'b0, n);
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL reconf_low: got %0d expected 16", n);
    end
    run_len(1'b1, n);
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL reconf_high: got %0d expected 16", n);
    end
    gen_on = 0;
  endtask

  task automatic test_tail();
    int r = 0;
    int r0 = 0;
    do_reset(1'b1, 3'd0, 8'd1);
    busy0_seen = 0;
    req_i = 3'b001;
    for (int k = 0; k < 100 && r < 3; k++) begin
      step();
      if (rise_strb_o) r++;
      if (rise0) r0++;
    end
    req_i = 3'b000;
    for (int k = 0; k < 80; k++) begin
      step();
      if (rise0) r0++;
      if (rise_strb_o) begin
        r++;
        if (r == 10) begin
          n_chk++;
          if ({tail_busy_o, sd_clk_en_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL tail_busy_7th: got %b expected 11",
              {tail_busy_o, sd_clk_en_o});
          end
        end
      end
    end
    n_chk++;
    if (r !== 11) begin
      n_fail++;
      $display("FAIL tail_rises: got %0d expected 11", r);
    end
    n_chk++;
    if ({tail_busy_o, sd_clk_en_o, sd_clk_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL tail_end: got %b expected 000",
        {tail_busy_o, sd_clk_en_o, sd_clk_o});
    end
    n_chk++;
    if (r0 !== 3) begin
      n_fail++;
      $display("FAIL notail_rises: got %0d expected 3", r0);
    end
    n_chk++;
    if (busy0_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL notail_busy: got %b expected 0", busy0_seen);
    end
  endtask

  task automatic test_stall_high();
    int n;
    int r = 0;
    do_reset(1'b1, 3'd0, 8'd2);
    req_i = 3'b001;
    wait_level(1'b1);
    stall_i = 2'b10;
    run_len(1'b1, n);
    n_chk++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL stall_high_len: got %0d expected 3", n);
    end
    for (int k = 0; k < 21; k++) begin
      step();
      if (rise_strb_o) r++;
    end
    n_chk++;
    if ({r[3:0], sd_clk_en_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL stall_no_rise: rises=%0d en=%b expected 0/0",
        r, sd_clk_en_o);
    end
    stall_i = 2'b00;
    n = 0;
    while (!rise_strb_o && n < 50) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL stall_release: got %0d expected 6", n);
    end
  endtask

  task automatic test_back_to_back();
    int tr = 0;
    int rs = 0;
    int n;
    do_reset(1'b1, 3'd0, 8'd1);
    req_i = 3'b001;
    n = 0;
    while (!rise_strb_o && n < 50) begin
      step();
      n++;
    end
    req_i = 3'b000;
    for (int k = 0; k < 100 && tr < 3; k++) begin
      step();
      if (rise_strb_o) tr++;
    end
    stall_i = 2'b01;
    for (int k = 0; k < 16; k++) begin
      step();
      if (rise_strb_o) rs++;
    end
    n_chk++;
    if ({rs[3:0], sd_clk_en_o, tail_busy_o} !== 6'b000001) begin
      n_fail++;
      $display("FAIL tail_stall: rises=%0d en=%b busy=%b expected 0/0/1",
        rs, sd_clk_en_o, tail_busy_o);
    end
    stall_i = 2'b00;
    for (int k = 0; k < 100 && tr < 7; k++) begin
      step();
      if (rise_strb_o) tr++;
    end
    n_chk++;
    if (tr !== 7) begin
      n_fail++;
      $display("FAIL tail_resume: got %0d expected 7", tr);
    end
    step(); step(); step();
    req_i = 3'b100;
    step();
    n_chk++;
    if ({rise_strb_o, tail_busy_o, sd_clk_o} !== 3'b101) begin
      n_fail++;
      $display("FAIL final_tail_rise: got %b expected 101",
        {rise_strb_o, tail_busy_o, sd_clk_o});
    end
    run_len(1'b1, n);
    n_chk++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL b2b_high: got %0d expected 2", n);
    end
    run_len(1'b0, n);
    n_chk++;
    if (n !== 2 || sd_clk_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: low=%0d sd=%b expected 2/1", n, sd_clk_o);
    end
    req_i = 3'b000;
  endtask

  initial begin
    test_reset();
    test_hs_div0();
    test_prescale_reconfig();
    test_tail();
    test_stall_high();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
